// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
// Sums a burst of signed 2N-bit products from the Booth multiplier into a
// (2N+G)-bit accumulator and holds the result until the consumer takes it.
// Valid/ready handshakes are used on both the input and output sides.
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator on signed
// overflow. When it is undefined, the accumulator wraps modulo 2^AW.
module booth_product_accumulator #(
  parameter int unsigned N = 32,
  parameter int unsigned G = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*N-1:0]          in_product,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [2*N+G-1:0] out_sum,
  output logic [15:0]             out_count,
  output logic                    out_overflow
);

  localparam int unsigned PW = 2 * N;
  localparam int unsigned AW = PW + G;
  localparam int unsigned CW = 16;

  localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic [CW-1:0]        CNT_MAX = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic signed [AW-1:0] p_ext;
  logic signed [AW-1:0] sum_raw;
  logic signed [AW-1:0] acc_add;
  logic                 add_ovf;
  logic                 accept;

  // Sign-extend the incoming product and form the raw sum plus its overflow flag.
  always_comb begin
    p_ext   = AW'($signed(in_product));
    sum_raw = acc_q + p_ext;
    add_ovf = (acc_q[AW-1] == p_ext[AW-1]) && (sum_raw[AW-1] != acc_q[AW-1]);
    accept  = in_valid && in_ready;
`ifdef ACC_SATURATE_EN
    if (add_ovf) begin
      acc_add = acc_q[AW-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_add = sum_raw;
    end
`else
    acc_add = sum_raw;
`endif
  end

  // Next-state logic and the accumulator datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_add;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
          ovf_d   = ovf_q | add_ovf;
          state_d = in_last ? HOLD : ACCUM;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and handshake flops; reset discards any partial burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_valid <= (state_d == HOLD);
      in_ready  <= (state_d != HOLD);
    end
  end

  // Result outputs come straight from the accumulator registers.
  assign out_sum      = acc_q;
  assign out_count    = cnt_q;
  assign out_overflow = ovf_q;

endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator
// Drives a default-size instance (N=32, G=8) and a small instance (N=4, G=1).
// The small instance is used to exercise accumulator overflow.
// Expected overflow results follow ACC_SATURATE_EN in the same way as the design.
module tb_booth_product_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_overflow;
  logic signed [63:0] a_in_product;
  logic signed [71:0] a_out_sum;
  logic [15:0]        a_out_count;

  logic               b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_overflow;
  logic signed [7:0]  b_in_product;
  logic signed [8:0]  b_out_sum;
  logic [15:0]        b_out_count;

  booth_product_accumulator #(.N(32), .G(8)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_product(a_in_product), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
    .out_count(a_out_count), .out_overflow(a_out_overflow)
  );

  booth_product_accumulator #(.N(4), .G(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
    .out_count(b_out_count), .out_overflow(b_out_overflow)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                 sel;
    int                 n;
    int                 gap;
    longint             p0, p1, p2, p3;
    logic signed [71:0] esum;
    int                 ecnt;
    bit                 eovf;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic signed [127:0] act, input logic signed [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit v, input longint p, input bit l);
    if (sel) begin
      b_in_valid = v; b_in_product = 8'(p); b_in_last = l;
    end else begin
      a_in_valid = v; a_in_product = p; a_in_last = l;
    end
  endtask

  task automatic set_oready(input bit sel, input bit r);
    if (sel) b_out_ready = r;
    else     a_out_ready = r;
  endtask

  function automatic bit rdy(input bit sel);
    return sel ? b_in_ready : a_in_ready;
  endfunction

  function automatic bit ovld(input bit sel);
    return sel ? b_out_valid : a_out_valid;
  endfunction

  // Wait (bounded) until in_ready is high before the next edge.
  task automatic wait_ready(input bit sel);
    int w = 0;
    while (!rdy(sel) && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w == 20) chk("in_ready_timeout", 0, 1);
  endtask

  // Reference: exact arithmetic with range check; clamp or wrap on overflow.
  task automatic model(input int aw, input int n, input longint pa[8],
                       output logic signed [127:0] s, output bit ovf);
    logic signed [127:0] mx, mn, span, e;
    mx   = (128'sd1 <<< (aw - 1)) - 128'sd1;
    mn   = -mx - 128'sd1;
    span = 128'sd1 <<< aw;
    s    = 0;
    ovf  = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = s + 128'(pa[i]);
      if (e > mx || e < mn) begin
        ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        e = (e > mx) ? mx : mn;
`else
        e = (e > mx) ? e - span : e + span;
`endif
      end
      s = e;
    end
  endtask

  // Send one burst, check latency, capture the result, then release the result.
  task automatic burst(input bit sel, input int n, input longint pa[8], input int gap,
                       output logic signed [127:0] s, output int cnt, output bit ov);
    for (int i = 0; i < n; i++) begin
      drive(sel, 1'b1, pa[i], i == n - 1);
      wait_ready(sel);
      @(posedge clk); #1;
      drive(sel, 1'b0, 0, 1'b0);
      if (i != n - 1 && gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
    chk("latency_out_valid", ovld(sel), 1);
    if (sel) begin
      s = b_out_sum; cnt = b_out_count; ov = b_out_overflow;
    end else begin
      s = a_out_sum; cnt = a_out_count; ov = a_out_overflow;
    end
    set_oready(sel, 1'b1);
    @(posedge clk); #1;
    set_oready(sel, 1'b0);
    chk("released_out_valid", ovld(sel), 0);
    chk("released_in_ready", rdy(sel), 1);
  endtask

  initial begin
    longint              pa[8];
    logic signed [127:0] s, es;
    int                  cnt;
    bit                  ov, eov;
    int                  n, gap;
    bit                  sel;

    rst = 1'b1;
    drive(0, 0, 0, 0); drive(1, 0, 0, 0);
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_out_sum", a_out_sum, 0);
    chk("rst_a_out_count", a_out_count, 0);
    chk("rst_a_out_overflow", a_out_overflow, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_out_sum", b_out_sum, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    vq.push_back('{sel:0, n:2, gap:0, p0:64'sd2614916801295, p1:-64'sd263875, p2:0, p3:0,
                   esum:72'sd2614916537420, ecnt:2, eovf:0});
    vq.push_back('{sel:0, n:1, gap:0, p0:0, p1:0, p2:0, p3:0, esum:0, ecnt:1, eovf:0});
    vq.push_back('{sel:0, n:1, gap:0, p0:-2008, p1:0, p2:0, p3:0, esum:-2008, ecnt:1, eovf:0});
    vq.push_back('{sel:0, n:3, gap:2, p0:736, p1:736, p2:736, p3:0, esum:2208, ecnt:3, eovf:0});
    vq.push_back('{sel:0, n:2, gap:1, p0:64'sh7FFFFFFFFFFFFFFF, p1:64'sh7FFFFFFFFFFFFFFF, p2:0, p3:0,
                   esum:72'sd18446744073709551614, ecnt:2, eovf:0});
    vq.push_back('{sel:0, n:4, gap:0, p0:64'sh8000000000000000, p1:64'sh8000000000000000,
                   p2:64'sh8000000000000000, p3:64'sh8000000000000000,
                   esum:-72'sd36893488147419103232, ecnt:4, eovf:0});
    vq.push_back('{sel:1, n:2, gap:0, p0:100, p1:-50, p2:0, p3:0, esum:50, ecnt:2, eovf:0});
`ifdef ACC_SATURATE_EN
    vq.push_back('{sel:1, n:4, gap:0, p0:64, p1:64, p2:64, p3:64, esum:255, ecnt:4, eovf:1});
    vq.push_back('{sel:1, n:3, gap:1, p0:-128, p1:-128, p2:-1, p3:0, esum:-256, ecnt:3, eovf:1});
    vq.push_back('{sel:1, n:4, gap:0, p0:127, p1:127, p2:127, p3:-128, esum:127, ecnt:4, eovf:1});
`else
    vq.push_back('{sel:1, n:4, gap:0, p0:64, p1:64, p2:64, p3:64, esum:-256, ecnt:4, eovf:1});
    vq.push_back('{sel:1, n:3, gap:1, p0:-128, p1:-128, p2:-1, p3:0, esum:255, ecnt:3, eovf:1});
    vq.push_back('{sel:1, n:4, gap:0, p0:127, p1:127, p2:127, p3:-128, esum:253, ecnt:4, eovf:1});
`endif

    foreach (vq[k]) begin
      pa = '{default: 0};
      pa[0] = vq[k].p0; pa[1] = vq[k].p1; pa[2] = vq[k].p2; pa[3] = vq[k].p3;
      burst(vq[k].sel, vq[k].n, pa, vq[k].gap, s, cnt, ov);
      chk($sformatf("vec%0d_sum", k), s, vq[k].esum);
      chk($sformatf("vec%0d_count", k), cnt, vq[k].ecnt);
      chk($sformatf("vec%0d_ovf", k), ov, vq[k].eovf);
    end

    // Backpressure: HOLD ignores in_valid and keeps its outputs stable.
    drive(0, 1, 9, 1);
    wait_ready(0);
    @(posedge clk); #1;
    drive(0, 1, 1000, 1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", a_in_ready, 0);
      chk("bp_out_valid", a_out_valid, 1);
      chk("bp_out_sum", a_out_sum, 9);
      chk("bp_out_count", a_out_count, 1);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("bp_idle_out_valid", a_out_valid, 0);
    chk("bp_idle_in_ready", a_in_ready, 1);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    chk("bp_next_out_valid", a_out_valid, 1);
    chk("bp_next_out_sum", a_out_sum, 1000);
    chk("bp_next_out_count", a_out_count, 1);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;

    // Asynchronous reset mid-burst discards the partial sum.
    drive(0, 1, 11, 0);
    wait_ready(0);
    @(posedge clk); #1;
    drive(0, 1, 22, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0);
    chk("pre_rst_sum", a_out_sum, 33);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", a_out_valid, 0);
    chk("midrst_in_ready", a_in_ready, 1);
    chk("midrst_out_sum", a_out_sum, 0);
    chk("midrst_out_count", a_out_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    pa = '{default: 0};
    pa[0] = 5;
    burst(0, 1, pa, 0, s, cnt, ov);
    chk("post_rst_sum", s, 5);
    chk("post_rst_count", cnt, 1);

    // Randomized bursts on both instances against the reference model.
    for (int r = 0; r < 40; r++) begin
      sel = r[0];
      n   = int'($urandom_range(1, 8));
      gap = int'($urandom_range(0, 2));
      pa  = '{default: 0};
      for (int i = 0; i < n; i++) begin
        if (sel) pa[i] = longint'(int'($urandom_range(0, 255)) - 128);
        else     pa[i] = longint'({$urandom, $urandom});
      end
      model(sel ? 9 : 72, n, pa, es, eov);
      burst(sel, n, pa, gap, s, cnt, ov);
      chk($sformatf("rand%0d_sum", r), s, es);
      chk($sformatf("rand%0d_count", r), cnt, n);
      chk($sformatf("rand%0d_ovf", r), ov, eov);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
